// File: rtl/soft_serializer_pkg.sv
// Shared state encoding, PRBS7 constants and word slicing helper for the
// multilane soft serializer.
package soft_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    SYNC      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int MAX_LANES = 16;
  localparam int MAX_WIDTH = 10;
  localparam int MAX_WORD  = MAX_LANES * MAX_WIDTH;

  // x^7 + x^6 + 1: feedback is the XOR of the two top stages
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  function automatic logic [MAX_WIDTH-1:0] lane_slice(
    input logic [MAX_WORD-1:0] word,
    input int                  i,
    input int                  width
  );
    logic [MAX_WORD-1:0]  shifted;
    logic [MAX_WIDTH-1:0] r;
    shifted = word >> (i * width);
    r = '0;
    for (int b = 0; b < MAX_WIDTH; b++) begin
      if (b < width) r[b] = shifted[b];
    end
    return r;
  endfunction

  function automatic logic prbs7_bit(input logic [6:0] s);
    return ^(s & PRBS7_TAPS);
  endfunction

endpackage

// File: rtl/soft_serializer_multilane_lane.sv
// One serial lane: a WIDTH-bit shift register whose output bit is registered,
// ordered LSB-first or MSB-first.
module serializer_lane #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_word,
  output logic             q
);

  logic [WIDTH-1:0] shreg;

  // Neither load nor shift means the lane is parked: drive 0 and drop any remainder.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      q     <= 1'b0;
      shreg <= '0;
    end else if (load) begin
      if (MSB_FIRST != 0) begin
        q     <= load_word[WIDTH-1];
        shreg <= {load_word[WIDTH-2:0], 1'b0};
      end else begin
        q     <= load_word[0];
        shreg <= {1'b0, load_word[WIDTH-1:1]};
      end
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        q     <= shreg[WIDTH-1];
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        q     <= shreg[0];
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
    end else begin
      q     <= 1'b0;
      shreg <= '0;
    end
  end

endmodule

// File: rtl/soft_serializer_multilane.sv
// Multi-lane fabric serializer with lock qualification, bonded start and idle fill.
// Optional per-lane PRBS7 source when SOFT_SERIALIZER_PRBS_EN is defined.
//
// state     | meaning
// IDLE      | transmitter disabled, pads off
// WAIT_LOCK | counting consecutive pll_lock-high cycles
// SYNC      | armed, waiting for channel_bond_sync_in to send the first word
// RUN       | words streaming, oe_out high
module soft_serializer_multilane
  import soft_serializer_pkg::*;
#(
  parameter int             NUM_LANES   = 4,
  parameter int             WIDTH       = 4,
  parameter int             MSB_FIRST   = 0,
  parameter int             LOCK_CYCLES = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       pll_lock,
  input  logic                       channel_bond_sync_in,
  input  logic [NUM_LANES*WIDTH-1:0] word_data,
  input  logic                       word_valid,
`ifdef SOFT_SERIALIZER_PRBS_EN
  input  logic                       prbs_mode,
`endif
  output logic                       word_ready,
  output logic [NUM_LANES-1:0]       q,
  output logic                       oe_out,
  output logic                       channel_bond_sync_out,
  output logic                       frame_start,
  output logic                       underflow,
  output logic                       lock_lost
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CYCLES - 1);

  state_t             state;
  logic [7:0]         lock_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic               live;
  logic               load_pt;
  logic               load_ok;
  logic               lane_shift;
  logic               prbs_active;
  logic [MAX_WORD-1:0] word_ext;

  // Reset, disable and lock loss all veto the load so no word is taken and then dropped.
  assign live       = !reset && enable && pll_lock;
  assign load_pt    = ((state == SYNC) && channel_bond_sync_in) ||
                      ((state == RUN) && (bit_cnt == LAST_BIT));
  assign load_ok    = live && load_pt;
  assign lane_shift = live && (state == RUN) && !load_pt;
  assign word_ext   = MAX_WORD'(word_data);

`ifdef SOFT_SERIALIZER_PRBS_EN
  assign prbs_active = prbs_mode;
`else
  assign prbs_active = 1'b0;
`endif

  assign word_ready = load_ok && !prbs_active;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state                 <= IDLE;
      lock_cnt              <= '0;
      bit_cnt               <= '0;
      oe_out                <= 1'b0;
      channel_bond_sync_out <= 1'b0;
      frame_start           <= 1'b0;
      underflow             <= 1'b0;
      lock_lost             <= 1'b0;
    end else begin
      channel_bond_sync_out <= 1'b0;
      frame_start           <= 1'b0;
      lock_lost             <= 1'b0;
      if (load_ok && !word_valid && !prbs_active) underflow <= 1'b1;

      if (!enable) begin
        state    <= IDLE;
        lock_cnt <= '0;
        bit_cnt  <= '0;
        oe_out   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
          end
          WAIT_LOCK: begin
            if (!pll_lock) begin
              lock_cnt <= '0;
            end else if (lock_cnt == LOCK_LAST) begin
              state    <= SYNC;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= lock_cnt + 8'd1;
            end
          end
          SYNC, RUN: begin
            if (!pll_lock) begin
              state     <= WAIT_LOCK;
              lock_cnt  <= '0;
              bit_cnt   <= '0;
              oe_out    <= 1'b0;
              lock_lost <= 1'b1;
            end else if (load_ok) begin
              if (state == SYNC) channel_bond_sync_out <= 1'b1;
              state       <= RUN;
              bit_cnt     <= '0;
              oe_out      <= 1'b1;
              frame_start <= 1'b1;
            end else if (state == RUN) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [WIDTH-1:0] lane_word;

`ifdef SOFT_SERIALIZER_PRBS_EN
    logic [6:0]       prbs_state;
    logic [6:0]       prbs_next;
    logic [WIDTH-1:0] prbs_word;

    // Advance the generator WIDTH steps per load; bit k of the word is the k-th output.
    always_comb begin
      prbs_next = prbs_state;
      prbs_word = '0;
      for (int b = 0; b < WIDTH; b++) begin
        prbs_word[b] = prbs7_bit(prbs_next);
        prbs_next    = {prbs_next[5:0], prbs_word[b]};
      end
    end

    always_ff @(posedge clk_in) begin
      if (reset) begin
        prbs_state <= PRBS7_SEED ^ 7'(g + 1);
      end else if (load_ok && prbs_mode) begin
        prbs_state <= prbs_next;
      end
    end

    always_comb begin
      lane_word = word_valid ? WIDTH'(lane_slice(word_ext, g, WIDTH)) : IDLE_WORD;
      if (prbs_mode) lane_word = prbs_word;
    end
`else
    always_comb begin
      lane_word = word_valid ? WIDTH'(lane_slice(word_ext, g, WIDTH)) : IDLE_WORD;
    end
`endif

    serializer_lane #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk_in    (clk_in),
      .reset     (reset),
      .load      (load_ok),
      .shift     (lane_shift),
      .load_word (lane_word),
      .q         (q[g])
    );
  end

endmodule

// File: tb/tb_soft_serializer_multilane.sv
// Directed bench with a stream scoreboard for soft_serializer_multilane
// (LSB-first and MSB-first instances driven in parallel).
module tb_soft_serializer_multilane;
  import soft_serializer_pkg::*;

  localparam int             NL       = 4;
  localparam int             W        = 4;
  localparam int             LOCKC    = 8;
  localparam logic [W-1:0]   IDLE_PAT = 4'b1010;

  typedef struct packed {
    logic [NL-1:0] q;
    logic          msb0;
    logic          frame;
  } ent_t;

  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic pll_lock = 1'b1;
  logic sync_in = 1'b0;
  logic word_valid = 1'b0;
  logic [NL*W-1:0] word_data = '0;
`ifdef SOFT_SERIALIZER_PRBS_EN
  logic prbs_mode = 1'b0;
  logic [6:0] m_prbs [NL];
`endif

  logic          word_ready, oe_out, sync_out, frame_start, underflow, lock_lost;
  logic [NL-1:0] q;
  logic          m_word_ready, m_oe_out, m_sync_out, m_frame_start, m_underflow, m_lock_lost;
  logic [NL-1:0] m_q;

  always #5 clk_in = ~clk_in;

  soft_serializer_multilane #(
    .NUM_LANES(NL), .WIDTH(W), .MSB_FIRST(0), .LOCK_CYCLES(LOCKC), .IDLE_WORD(IDLE_PAT)
  ) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .pll_lock(pll_lock),
    .channel_bond_sync_in(sync_in), .word_data(word_data), .word_valid(word_valid),
`ifdef SOFT_SERIALIZER_PRBS_EN
    .prbs_mode(prbs_mode),
`endif
    .word_ready(word_ready), .q(q), .oe_out(oe_out), .channel_bond_sync_out(sync_out),
    .frame_start(frame_start), .underflow(underflow), .lock_lost(lock_lost)
  );

  soft_serializer_multilane #(
    .NUM_LANES(NL), .WIDTH(W), .MSB_FIRST(1), .LOCK_CYCLES(LOCKC), .IDLE_WORD(IDLE_PAT)
  ) dut_msb (
    .clk_in(clk_in), .reset(reset), .enable(enable), .pll_lock(pll_lock),
    .channel_bond_sync_in(sync_in), .word_data(word_data), .word_valid(word_valid),
`ifdef SOFT_SERIALIZER_PRBS_EN
    .prbs_mode(prbs_mode),
`endif
    .word_ready(m_word_ready), .q(m_q), .oe_out(m_oe_out), .channel_bond_sync_out(m_sync_out),
    .frame_start(m_frame_start), .underflow(m_underflow), .lock_lost(m_lock_lost)
  );

  int     n_pass = 0;
  int     n_fail = 0;
  int     n_total = 0;
  state_t m_st = IDLE;
  int     m_cnt = 0;
  int     m_bit = 0;
  logic   m_uf = 1'b0;
  logic   m_lost = 1'b0;
  logic   m_sync = 1'b0;
  logic   last_ld = 1'b0;
  ent_t   sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [NL*W-1:0] wv);
    for (int k = 0; k < W; k++) begin
      ent_t e;
      for (int i = 0; i < NL; i++) e.q[i] = wv[i*W + k];
      e.msb0  = wv[W-1-k];
      e.frame = (k == 0);
      sb.push_back(e);
    end
  endtask

`ifdef SOFT_SERIALIZER_PRBS_EN
  task automatic prbs_seed();
    for (int i = 0; i < NL; i++) m_prbs[i] = 7'h7F ^ 7'(i + 1);
  endtask

  task automatic prbs_word(output logic [NL*W-1:0] wv);
    logic b;
    wv = '0;
    for (int i = 0; i < NL; i++) begin
      for (int k = 0; k < W; k++) begin
        b = m_prbs[i][6] ^ m_prbs[i][5];
        wv[i*W + k] = b;
        m_prbs[i] = {m_prbs[i][5:0], b};
      end
    end
  endtask
`endif

  // One clock: predict from the inputs of this cycle, advance, then compare outputs.
  task automatic step();
    logic ld;
    logic prbs;
    logic [NL*W-1:0] wv;
    ent_t e;
    #1;
    prbs = 1'b0;
`ifdef SOFT_SERIALIZER_PRBS_EN
    prbs = prbs_mode;
`endif
    ld = !reset && enable && pll_lock &&
         ((m_st == SYNC && sync_in) || (m_st == RUN && m_bit == W-1));
    last_ld = ld;
    chk("word_ready", word_ready, ld && !prbs);
    m_lost = 1'b0;
    m_sync = 1'b0;
    if (reset) begin
      m_st = IDLE; m_cnt = 0; m_bit = 0; m_uf = 1'b0; sb.delete();
`ifdef SOFT_SERIALIZER_PRBS_EN
      prbs_seed();
`endif
    end else if (!enable) begin
      m_st = IDLE; m_cnt = 0; m_bit = 0; sb.delete();
    end else begin
      case (m_st)
        IDLE: begin m_st = WAIT_LOCK; m_cnt = 0; end
        WAIT_LOCK: begin
          if (!pll_lock) m_cnt = 0;
          else if (m_cnt == LOCKC-1) begin m_st = SYNC; m_cnt = 0; end
          else m_cnt++;
        end
        default: begin
          if (!pll_lock) begin
            m_st = WAIT_LOCK; m_cnt = 0; m_bit = 0; m_lost = 1'b1; sb.delete();
          end else if (ld) begin
            m_sync = (m_st == SYNC);
            m_st = RUN;
            m_bit = 0;
            if (prbs) begin
`ifdef SOFT_SERIALIZER_PRBS_EN
              prbs_word(wv);
`else
              wv = '0;
`endif
            end else if (word_valid) wv = word_data;
            else begin
              wv = {NL{IDLE_PAT}};
              m_uf = 1'b1;
            end
            push_word(wv);
          end else if (m_st == RUN) m_bit++;
        end
      endcase
    end
    @(posedge clk_in);
    #1;
    chk("state", 32'(dut.state), 32'(m_st));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q", q, e.q);
      chk("q_msb_lane0", m_q[0], e.msb0);
      chk("frame_start", frame_start, e.frame);
      chk("oe_out", oe_out, 1);
    end else begin
      chk("q_parked", q, 0);
      chk("q_msb_parked", m_q[0], 0);
      chk("frame_start_parked", frame_start, 0);
      chk("oe_out_parked", oe_out, 0);
    end
    chk("sync_out", sync_out, m_sync);
    chk("lock_lost", lock_lost, m_lost);
    chk("underflow", underflow, m_uf);
  endtask

  task automatic wait_load(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      step();
      done = last_ld;
    end
    n_total++;
    assert (done) n_pass++;
    else begin
      n_fail++;
      $error("FAIL load_timeout observed=no_load expected=load");
    end
  endtask

  task automatic send_word(input logic [NL*W-1:0] w);
    word_data  = w;
    word_valid = 1'b1;
    wait_load(2*W + 2);
  endtask

  // Steps until the DUT reports SYNC; early_at pulses sync_in while still locking.
  task automatic arm(input int exp_cycles, input int early_at);
    int  n;
    bit  hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 40) begin
      sync_in = (n + 1 == early_at);
      step();
      n++;
      hit = (dut.state == SYNC);
    end
    sync_in = 1'b0;
    chk("arm_cycles", n, exp_cycles);
  endtask

  initial begin
`ifdef SOFT_SERIALIZER_PRBS_EN
    prbs_seed();
`endif
    repeat (3) step();
    chk("reset_state", 32'(dut.state), 32'(IDLE));

    reset  = 1'b0;
    enable = 1'b1;
    arm(LOCKC + 1, 5);

    sync_in = 1'b1;
    send_word(16'hA5C3);
    sync_in = 1'b0;
    send_word(16'h1234);
    send_word(16'h5678);

    word_valid = 1'b0;
    wait_load(2*W);
    send_word(16'h0F0F);
    word_valid = 1'b0;
    repeat (2*W) step();

    send_word(16'h9ABC);
    step();
    step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    arm(LOCKC, 0);

    sync_in = 1'b1;
    send_word(16'hBEEF);
    sync_in = 1'b0;
    step();
    enable   = 1'b0;
    pll_lock = 1'b0;
    step();
    enable   = 1'b1;
    pll_lock = 1'b1;
    arm(LOCKC + 1, 0);

    sync_in = 1'b1;
    send_word(16'hC0DE);
    sync_in = 1'b0;
`ifdef SOFT_SERIALIZER_PRBS_EN
    prbs_mode = 1'b1;
    repeat (3*W) step();
    prbs_mode = 1'b0;
`endif
    send_word(16'h3C96);
    step();
    reset = 1'b1;
    step();
    chk("reset_in_run_state", 32'(dut.state), 32'(IDLE));
    chk("reset_in_run_underflow", underflow, 0);
    reset = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/soft_serializer_multilane.md
Name: soft_serializer_multilane

Overview:
- Fabric-logic, multi-lane parallel-to-serial transmitter. It generalises the single-lane SDR hard-serializer usage to NUM_LANES lock-stepped lanes with configurable WIDTH and bit order.
- Adds a valid/ready word handshake, PLL-lock qualification, a channel-bond sync start, and idle-word fill with underflow reporting.
- Sits between the fabric word source and output pads/tri-state buffers, in the same single fabric clock domain.

Parameters:
- NUM_LANES, 4, number of serial lanes (1-16).
- WIDTH, 4, bits per lane per word (3-10).
- MSB_FIRST, 0, 0 = lane bit 0 shifted out first; 1 = bit WIDTH-1 first.
- LOCK_CYCLES, 8, consecutive pll_lock-high cycles required before arming (1-255).
- IDLE_WORD, 0, per-lane WIDTH-bit pattern sent when no word is available.

Ports:
- clk_in  input  1  fabric clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  transmitter enable.
- pll_lock  input  1  PLL lock status (synchronous to clk_in).
- channel_bond_sync_in  input  1  bond start strobe shared by all bonded blocks.
- word_data  input  NUM_LANES*WIDTH  parallel word; lane i = word_data[i*WIDTH +: WIDTH].
- word_valid  input  1  word_data is valid.
- word_ready  output  1  word accepted this cycle when word_valid is also high.
- q  output  NUM_LANES  serial data, one bit per lane.
- oe_out  output  1  tri-state enable for the pads; high only in RUN.
- channel_bond_sync_out  output  1  one-cycle pulse when RUN begins.
- frame_start  output  1  high while q carries bit 0 of a word.
- underflow  output  1  sticky; cleared only by reset.
- lock_lost  output  1  one-cycle pulse when lock drops in SYNC or RUN.

Behaviour:
- Reset values: q=0, oe_out=0, word_ready=0, channel_bond_sync_out=0, frame_start=0, underflow=0, lock_lost=0; state=IDLE; lock and bit counters = 0. All outputs are registered except word_ready, which is combinational from state, bit counter and sync input.
- IDLE: go to WAIT_LOCK when enable=1.
- WAIT_LOCK: lock_cnt increments while pll_lock=1 and clears to 0 when pll_lock=0. Go to SYNC when lock_cnt reaches LOCK_CYCLES-1 with pll_lock still high.
- SYNC: hold q=0 and oe_out=0. On channel_bond_sync_in=1, go to RUN and pulse channel_bond_sync_out next cycle. The first word loads in this same cycle (see load rule).
- RUN: bit_cnt counts 0..WIDTH-1 and wraps. Each cycle, each lane's shift register drives q[i] with its next bit per MSB_FIRST. oe_out=1.
- Load point: SYNC with sync_in=1, or RUN with bit_cnt=WIDTH-1.
  - word_ready=1 only at a load point.
  - If word_valid=1 there, word_data is loaded.
  - Otherwise IDLE_WORD is loaded into every lane and underflow is set.
- Latency: word accepted in cycle t produces its first bit on q in cycle t+1 and its last in cycle t+WIDTH. There is no bubble between consecutive words.
- frame_start=1 in the cycle q carries bit_cnt=0.
- pll_lock=0 in SYNC or RUN:
  - next cycle go to WAIT_LOCK, oe_out=0, q=0, lock_lost=1 pulse.
  - A partially sent word is discarded; no word is accepted in that cycle.
- enable=0 in any state: next cycle go to IDLE, q=0, oe_out=0. Takes priority over lock loss (no lock_lost pulse).
- Priority: reset > enable=0 > pll_lock=0 > sync/load.
- word_data is ignored outside load points; word_valid may stay high.

Optional Feature:
- Macro SOFT_SERIALIZER_PRBS_EN.
- When defined: adds input prbs_mode (1 bit). With prbs_mode=1 in RUN, each lane loads WIDTH bits of its own PRBS7 generator (x^7+x^6+1, seed 7'h7F XOR lane index+1) at every load point. word_ready is held 0, and underflow is not set.
- When undefined: no port and no PRBS logic exist.

Decomposition:
- Package soft_serializer_pkg:
  - state enum (IDLE, WAIT_LOCK, SYNC, RUN).
  - PRBS7 polynomial/seed constants.
  - function lane_slice(word,i).
- One natural sub-module: serializer_lane. It holds one lane's shift register and MSB_FIRST ordering, and is instantiated NUM_LANES times under a shared bit counter and FSM.

Test Plan:
- Default parameters; pll_lock high from cycle 0; enable=1; sync_in pulse → state reaches SYNC after 8 lock cycles; channel_bond_sync_out pulses one cycle after sync_in.
- word 16'hA5C3 held valid at first load → lane0 q[0] = 1,1,0,0 (LSB first). MSB_FIRST=1 → 0,0,1,1. frame_start high on the first bit of each word.
- Back-to-back valid words 16'h1234 and 16'h5678 → continuous 8-cycle stream with no gap; word_ready high exactly every 4th cycle.
- word_valid=0 at a load point with IDLE_WORD=4'b1010 → every lane outputs 0,1,0,1; underflow=1 and stays set.
- pll_lock dropped mid-word (bit_cnt=2) → next cycle q=0, oe_out=0, lock_lost=1 for one cycle; re-arm needs 8 fresh lock cycles plus a sync.
- reset asserted in RUN → next edge: all outputs 0 and state IDLE. With SOFT_SERIALIZER_PRBS_EN and prbs_mode=1, lane0 matches the PRBS7 reference sequence from seed 7'h7E.
